// File: rtl/secure_mem_scrub_master.sv
// Avalon-MM bulk master for the s2 port of the secure on-chip memory.
// Zeroizes, pattern-fills or checksums a word range without CPU involvement.
module secure_mem_scrub_master #(
    parameter int ADDR_W       = 13,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       pattern,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted,
    output logic [31:0]       result,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ZERO     = 2'd0;
    localparam logic [1:0] OP_FILL     = 2'd1;
    localparam logic [1:0] OP_CHECKSUM = 2'd2;
    localparam logic [1:0] OP_RESERVED = 2'd3;

    state_t state, state_next;

    // Operation parameters latched at start
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       pattern_q;

    // Transfer index within the range
    logic [ADDR_W:0]   idx;

    // One bit per read in flight; the top bit marks data arriving this cycle
    logic [READ_LATENCY-1:0] rd_vld;
    logic [READ_LATENCY-1:0] rd_vld_next;

    logic [ADDR_W+1:0] range_end;
    logic              range_bad;
    logic              accept;
    logic              rd_accept;
    logic              last_xfer;
    logic              is_write_op;
    logic              run_stop;

    assign accept      = avm_chipselect & ~avm_waitrequest;
    assign rd_accept   = accept & ~avm_write;
    assign last_xfer   = (idx == count_q - 1'b1);
    assign is_write_op = (op_q != OP_CHECKSUM);
    assign run_stop    = abort | (accept & last_xfer);

    // Range check at full width so base+count can never alias past DEPTH
    always_comb begin
        range_end = {2'b00, base_q} + {1'b0, count_q};
        range_bad = (count_q == '0) || (op_q == OP_RESERVED) ||
                    (range_end > (ADDR_W+2)'(DEPTH));
    end

    // Read-valid pipeline advance, shared by RUN accounting and DRAIN exit
    always_comb begin
        rd_vld_next = (rd_vld << 1) | READ_LATENCY'(rd_accept);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = range_bad ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (run_stop) begin
                    state_next = is_write_op ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_vld_next == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operation latch, status flags and checksum accumulation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q      <= OP_ZERO;
            base_q    <= '0;
            count_q   <= '0;
            pattern_q <= '0;
            error     <= 1'b0;
            aborted   <= 1'b0;
            result    <= '0;
            rd_vld    <= '0;
        end else begin
            rd_vld <= rd_vld_next;
            if (rd_vld[READ_LATENCY-1]) begin
                result <= result + avm_readdata;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        base_q    <= base_addr;
                        count_q   <= word_count;
                        pattern_q <= pattern;
                        error     <= 1'b0;
                        aborted   <= 1'b0;
                        result    <= '0;
                    end
                end
                S_CHECK: begin
                    if (range_bad) begin
                        error <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus request registers; held untouched while the slave stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            idx            <= '0;
        end else begin
            case (state)
                S_CHECK: begin
                    if (!range_bad) begin
                        avm_chipselect <= 1'b1;
                        avm_write      <= is_write_op;
                        avm_byteenable <= '1;
                        avm_address    <= base_q;
                        avm_writedata  <= (op_q == OP_FILL) ? pattern_q : '0;
                        idx            <= '0;
                    end
                end
                S_RUN: begin
                    if (run_stop) begin
                        avm_chipselect <= 1'b0;
                        avm_write      <= 1'b0;
                        avm_byteenable <= '0;
                    end else if (accept) begin
                        idx         <= idx + 1'b1;
                        avm_address <= avm_address + 1'b1;
                    end
                end
                default: begin
                    avm_chipselect <= 1'b0;
                    avm_write      <= 1'b0;
                    avm_byteenable <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secure_mem_scrub_master.sv
// Directed bench for secure_mem_scrub_master with a behavioural memory slave
// and a transfer scoreboard checked every cycle.
module tb_secure_mem_scrub_master;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 5120;
    localparam int RL     = 1;
    localparam logic [31:0] JUNK = 32'hBAD0_C0DE;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [1:0]        op;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       pattern;
    logic              busy;
    logic              done;
    logic              error;
    logic              aborted;
    logic [31:0]       result;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    secure_mem_scrub_master #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .op(op),
        .base_addr(base_addr),
        .word_count(word_count),
        .pattern(pattern),
        .busy(busy),
        .done(done),
        .error(error),
        .aborted(aborted),
        .result(result),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write(avm_write),
        .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    // Memory slave: preload port, write port, fixed-latency read pipe
    logic [31:0]       mem [DEPTH];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [31:0]       pl_data = '0;
    logic [31:0]       rd_pipe_d [RL] = '{default: JUNK};
    logic              rd_pipe_v [RL] = '{default: 1'b0};
    int acc_cnt   = 0;
    int wr_cnt    = 0;
    int rd_cnt    = 0;
    int stall_cyc = 0;
    int stall_at  = -1;
    int stall_len = 0;

    assign avm_waitrequest = avm_chipselect && (acc_cnt == stall_at) && (stall_cyc < stall_len);
    assign avm_readdata    = rd_pipe_v[RL-1] ? rd_pipe_d[RL-1] : JUNK;

    // Slave behaviour at the bus clock edge
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        for (int i = RL - 1; i > 0; i--) begin
            rd_pipe_d[i] <= rd_pipe_d[i-1];
            rd_pipe_v[i] <= rd_pipe_v[i-1];
        end
        rd_pipe_v[0] <= 1'b0;
        rd_pipe_d[0] <= JUNK;
        if (avm_waitrequest) stall_cyc <= stall_cyc + 1;
        if (avm_chipselect && !avm_waitrequest) begin
            acc_cnt <= acc_cnt + 1;
            if (avm_write) begin
                mem[avm_address] <= avm_writedata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_pipe_v[0] <= 1'b1;
                rd_pipe_d[0] <= mem[avm_address];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [31:0]       data;
    } xfer_t;

    xfer_t sb[$];
    logic  mon_en   = 1'b0;
    int    st_seen  = 0;
    logic [31:0] tbl [100];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard step, run once per cycle mid-period
    task automatic monitor();
        xfer_t e;
        if (!mon_en) return;
        if (avm_chipselect && sb.size() != 0) begin
            check("byteenable", {28'b0, avm_byteenable}, 32'hF);
            if (!avm_waitrequest) begin
                e = sb.pop_front();
                check("xfer_addr", {19'b0, avm_address}, {19'b0, e.addr});
                check("xfer_we", {31'b0, avm_write}, {31'b0, e.we});
                if (e.we) check("xfer_data", avm_writedata, e.data);
            end else begin
                st_seen++;
                check("stall_addr", {19'b0, avm_address}, {19'b0, sb[0].addr});
                check("stall_data", avm_writedata, sb[0].data);
            end
        end else if (sb.size() == 0) begin
            check("idle_cs", {31'b0, avm_chipselect}, 32'h0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic preload(input int addr, input logic [31:0] data);
        tick();
        pl_en   = 1'b1;
        pl_addr = ADDR_W'(addr);
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic push_range(input int base, input int n, input logic we, input logic [31:0] data);
        xfer_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = ADDR_W'(base + i);
            e.we   = we;
            e.data = data;
            sb.push_back(e);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input int base, input int n, input logic [31:0] pat);
        tick();
        op         = o;
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W+1)'(n);
        pattern    = pat;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Cycles from the start cycle to the done pulse; bounded
    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (!done && lat < 400) begin
            tick();
            lat++;
        end
        check(tag, {31'b0, done}, 32'h1);
    endtask

    initial begin
        int lat;
        int w0;
        int r0;
        int k;
        int guard;
        logic [31:0] esum;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0;
        base_addr = '0; word_count = '0; pattern = '0;
        tick(); tick(); tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_error", {31'b0, error}, 0);
        check("rst_aborted", {31'b0, aborted}, 0);
        check("rst_result", result, 0);
        check("rst_cs", {31'b0, avm_chipselect}, 0);
        check("rst_we", {31'b0, avm_write}, 0);
        check("rst_addr", {19'b0, avm_address}, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_be", {28'b0, avm_byteenable}, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Zeroize four words, neighbour must survive
        for (int i = 0; i < 4; i++) preload(16'h10 + i, 32'hDEADBEEF);
        preload(16'h14, 32'h12345678);
        push_range(16'h10, 4, 1'b1, 32'h0);
        start_op(2'd0, 16'h10, 4, 32'h0);
        check("zero_busy", {31'b0, busy}, 1);
        wait_done("zero_done", lat);
        check("zero_lat", lat, 6);
        check("zero_err", {31'b0, error}, 0);
        tick();
        check("zero_busy_low", {31'b0, busy}, 0);
        for (int i = 0; i < 4; i++) check("zero_mem", mem[16'h10 + i], 32'h0);
        check("zero_neighbour", mem[16'h14], 32'h12345678);
        check("zero_sb_empty", sb.size(), 0);

        // Checksum with carry wrap
        preload(16'h20, 32'h00000001);
        preload(16'h21, 32'hFFFFFFFF);
        preload(16'h22, 32'h00000005);
        push_range(16'h20, 3, 1'b0, 32'h0);
        start_op(2'd2, 16'h20, 3, 32'h0);
        wait_done("sum_done", lat);
        check("sum_lat", lat, 3 + 2 + RL);
        check("sum_result", result, 32'h00000005);
        check("sum_err", {31'b0, error}, 0);
        tick();

        // Range / op errors: no bus activity, done two cycles after start
        start_op(2'd1, 5118, 4, 32'h1);
        wait_done("rng_done", lat);
        check("rng_lat", lat, 2);
        check("rng_err", {31'b0, error}, 1);
        check("rng_result_clr", result, 0);
        tick();
        start_op(2'd1, 16'h30, 0, 32'h1);
        wait_done("cnt0_done", lat);
        check("cnt0_lat", lat, 2);
        check("cnt0_err", {31'b0, error}, 1);
        tick();
        start_op(2'd3, 16'h30, 2, 32'h1);
        wait_done("op3_done", lat);
        check("op3_lat", lat, 2);
        check("op3_err", {31'b0, error}, 1);
        tick();
        // Exact fit at the top of memory is legal
        push_range(DEPTH - 2, 2, 1'b1, 32'h0F0F0F0F);
        start_op(2'd1, DEPTH - 2, 2, 32'h0F0F0F0F);
        wait_done("top_done", lat);
        check("top_err", {31'b0, error}, 0);
        check("top_lat", lat, 4);
        tick();
        check("top_mem", mem[DEPTH - 1], 32'h0F0F0F0F);

        // Fill with a three-cycle stall on the second transfer
        w0 = wr_cnt;
        st_seen = 0;
        stall_at = acc_cnt + 1;
        stall_len = 3;
        push_range(16'h40, 3, 1'b1, 32'hA5A5A5A5);
        start_op(2'd1, 16'h40, 3, 32'hA5A5A5A5);
        wait_done("stall_done", lat);
        check("stall_lat", lat, 3 + 2 + 3);
        check("stall_cycles", st_seen, 3);
        check("stall_writes", wr_cnt - w0, 3);
        tick();
        stall_len = 0;
        for (int i = 0; i < 3; i++) check("stall_mem", mem[16'h40 + i], 32'hA5A5A5A5);

        // Abort a long checksum after the tenth accepted read
        for (int i = 0; i < 100; i++) begin
            tbl[i] = 32'h9E3779B9 * 32'(i + 1);
            preload(16'h100 + i, tbl[i]);
        end
        r0 = rd_cnt;
        push_range(16'h100, 100, 1'b0, 32'h0);
        start_op(2'd2, 16'h100, 100, 32'h0);
        guard = 0;
        while ((rd_cnt - r0) < 10 && guard < 300) begin
            tick();
            guard++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort_done", lat);
        k = rd_cnt - r0;
        check("abort_reads", 32'(k == 10 || k == 11), 1);
        check("abort_flag", {31'b0, aborted}, 1);
        check("abort_err", {31'b0, error}, 0);
        esum = 32'h0;
        for (int i = 0; i < k && i < 100; i++) esum = esum + tbl[i];
        check("abort_result", result, esum);
        sb.delete();
        tick();

        // Reset in the middle of a long zeroize
        for (int i = 0; i < 50; i++) preload(16'h200 + i, 32'h5A5A0000 + 32'(i));
        w0 = wr_cnt;
        push_range(16'h200, 50, 1'b1, 32'h0);
        start_op(2'd0, 16'h200, 50, 32'h0);
        guard = 0;
        while ((wr_cnt - w0) < 5 && guard < 100) begin
            tick();
            guard++;
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        check("mid_rst_cs", {31'b0, avm_chipselect}, 0);
        sb.delete();
        k = wr_cnt - w0;
        check("mid_rst_partial", 32'(k >= 5 && k < 50), 1);
        for (int i = 0; i < 50; i++)
            check("mid_rst_mem", mem[16'h200 + i], (i < k) ? 32'h0 : 32'h5A5A0000 + 32'(i));

        // Normal operation after the reset
        preload(16'h300, 32'h11111111);
        preload(16'h301, 32'h22222222);
        push_range(16'h300, 2, 1'b1, 32'h0);
        start_op(2'd0, 16'h300, 2, 32'h0);
        wait_done("post_done", lat);
        check("post_lat", lat, 4);
        check("post_err", {31'b0, error}, 0);
        check("post_aborted", {31'b0, aborted}, 0);
        tick();
        check("post_mem0", mem[16'h300], 32'h0);
        check("post_mem1", mem[16'h301], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
